// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag layout and result-stage entry format.
// Used by the ALU and by alu_result_stage (ALU_RES_STATS_EN adds stats).
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FLAG_W  = 4;
  localparam int FLAG_Z  = 0;
  localparam int FLAG_CY = 1;
  localparam int FLAG_OV = 2;
  localparam int FLAG_DZ = 3;

  localparam logic [7:0] DZ_RESULT = 8'hFF;

  localparam int ENTRY_W = 2 + 8 + FLAG_W;

  typedef struct packed {
    logic [1:0]        op;
    logic [7:0]        result;
    logic [FLAG_W-1:0] flags;
  } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO, power-of-two depth, registered count.
// Ready/valid status comes from count only; storage clears on reset.
module alu_res_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign wr_ready = (count != FULL_CNT);
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rptr];

  // pointer, count and storage update; reset wins over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag derivation, div-by-zero sanitising.
// Option ALU_RES_STATS_EN adds a saturating dz_count output.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic [7:0]        f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic [1:0]        out_op
`ifdef ALU_RES_STATS_EN
  ,
  output logic [7:0]        dz_count
`endif
);

  logic [8:0]        sum9;
  logic [15:0]       prod;
  logic [7:0]        res;
  logic [FLAG_W-1:0] flags;
  res_entry_t        wr_e;
  res_entry_t        rd_e;

  // flags from the incoming ALU transaction; z judged after sanitising
  always_comb begin
    sum9  = {1'b0, a} + {1'b0, b};
    prod  = 16'(a) * 16'(b);
    flags = '0;
    res   = f;
    unique case (1'b1)
      (op == OP_ADD): begin
        flags[FLAG_CY] = sum9[8];
        flags[FLAG_OV] = (a[7] == b[7]) && (f[7] != a[7]);
      end
      (op == OP_SUB): begin
        flags[FLAG_CY] = (a < b);
        flags[FLAG_OV] = (a[7] != b[7]) && (f[7] != a[7]);
      end
      (op == OP_MUL): begin
        flags[FLAG_OV] = (prod > 16'd255);
      end
      (op == OP_DIV): begin
        flags[FLAG_DZ] = (b == 8'h00);
      end
      default: ;
    endcase
    if (flags[FLAG_DZ]) begin
      res = DZ_RESULT;
    end
    flags[FLAG_Z] = (res == 8'h00);
  end

  assign wr_e.op     = op;
  assign wr_e.result = res;
  assign wr_e.flags  = flags;

  alu_res_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_e),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_e)
  );

  assign out_op     = rd_e.op;
  assign out_result = rd_e.result;
  assign out_flags  = rd_e.flags;

`ifdef ALU_RES_STATS_EN
  // saturating count of accepted divide-by-zero pushes
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_count <= '0;
    end else if (in_valid && in_ready && flags[FLAG_DZ]
                 && (dz_count != 8'hFF)) begin
      dz_count <= dz_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (DEPTH=2).
// Builds with or without ALU_RES_STATS_EN.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] f = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [1:0] out_op;
`ifdef ALU_RES_STATS_EN
  logic [7:0] dz_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int dz_exp = 0;
  logic [13:0] sb [$];

  alu_result_stage #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .f          (f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_op     (out_op)
`ifdef ALU_RES_STATS_EN
    ,
    .dz_count   (dz_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu_f(input logic [1:0] o,
                                       input logic [7:0] x,
                                       input logic [7:0] y);
    case (o)
      2'b00: return x + y;
      2'b01: return x - y;
      2'b10: return 8'((16'(x) * 16'(y)) & 16'h00FF);
      default: return (y == 0) ? 8'($urandom) : x / y;
    endcase
  endfunction

  function automatic logic [13:0] model(input logic [1:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic [7:0] r);
    int sx, sy, s;
    logic dz, ov, cy, z;
    logic [7:0] res;
    sx = $signed(x);
    sy = $signed(y);
    dz = 0; ov = 0; cy = 0;
    res = r;
    case (o)
      2'b00: begin
        s  = sx + sy;
        ov = (s > 127) || (s < -128);
        cy = (int'(x) + int'(y)) > 255;
      end
      2'b01: begin
        s  = sx - sy;
        ov = (s > 127) || (s < -128);
        cy = int'(x) < int'(y);
      end
      2'b10: ov = (int'(x) * int'(y)) > 255;
      default: begin
        dz = (y == 0);
        if (dz) res = 8'hFF;
      end
    endcase
    z = (res == 0);
    return {o, res, dz, ov, cy, z};
  endfunction

  always @(negedge clk) begin
    logic [13:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_size", 16'(sb.size()), 16'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_op", 16'(out_op), 16'(e[13:12]));
          chk("sb_res", 16'(out_result), 16'(e[11:4]));
          chk("sb_flags", 16'(out_flags), 16'(e[3:0]));
        end
      end
      if (in_valid && in_ready) begin
        e = model(op, a, b, f);
        sb.push_back(e);
        if (e[3] && dz_exp < 255) dz_exp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] o,
                        input logic [7:0] x,
                        input logic [7:0] y);
    op = o; a = x; b = y;
    f = alu_f(o, x, y);
  endtask

  task automatic send(input logic [1:0] o,
                      input logic [7:0] x,
                      input logic [7:0] y);
    set_in(o, x, y);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    dz_exp = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ordy"}, 16'(in_ready), 16'd1);
    chk({tag, "_ovld"}, 16'(out_valid), 16'd0);
    chk({tag, "_res"}, 16'(out_result), 16'd0);
    chk({tag, "_flg"}, 16'(out_flags), 16'd0);
    chk({tag, "_op"}, 16'(out_op), 16'd0);
  endtask

  task automatic head(input string tag,
                      input logic [7:0] r,
                      input logic [3:0] fl);
    chk({tag, "_vld"}, 16'(out_valid), 16'd1);
    chk({tag, "_res"}, 16'(out_result), 16'(r));
    chk({tag, "_flg"}, 16'(out_flags), 16'(fl));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    do_reset();
    chk_idle("rst0");

    send(2'b00, 8'hFF, 8'h01);
    head("add", 8'h00, 4'b0011);
    send(2'b01, 8'h80, 8'h01);
    head("sub", 8'h7F, 4'b0100);
    send(2'b10, 8'h10, 8'h10);
    head("mul", 8'h00, 4'b0101);
    send(2'b11, 8'h25, 8'h00);
`ifdef ALU_RES_STATS_EN
    chk("dz_cnt1", 16'(dz_count), 16'd1);
`endif
    head("div", 8'hFF, 4'b1000);

    send(2'b00, 8'h11, 8'h22);
    send(2'b01, 8'h05, 8'h09);
    chk("full_rdy", 16'(in_ready), 16'd0);
    chk("full_vld", 16'(out_valid), 16'd1);
    set_in(2'b10, 8'h03, 8'h07);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("held_rdy", 16'(in_ready), 16'd1);
    chk("held_vld", 16'(out_valid), 16'd1);
    tick();
    chk("pp_rdy", 16'(in_ready), 16'd1);
    chk("pp_vld", 16'(out_valid), 16'd1);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("pp_drain", 16'(out_valid), 16'd0);

    send(2'b00, 8'h7F, 8'h01);
    send(2'b11, 8'h40, 8'h00);
    chk("pre_rst", 16'(in_ready), 16'd0);
    set_in(2'b00, 8'h01, 8'h01);
    in_valid = 1'b1;
    out_ready = 1'b1;
    do_reset();
    chk_idle("rst1");
`ifdef ALU_RES_STATS_EN
    chk("dz_rst", 16'(dz_count), 16'd0);
`endif
    send(2'b01, 8'h00, 8'h01);
    head("post", 8'hFF, 4'b0010);
    chk("post_empty", 16'(out_valid), 16'd0);

    for (int i = 0; i < 200; i++) begin
      set_in(2'($urandom_range(0, 3)), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("sb_drain", 16'(sb.size()), 16'd0);
`ifdef ALU_RES_STATS_EN
    chk("dz_rand", 16'(dz_count), 16'(dz_exp));
    set_in(2'b11, 8'h25, 8'h00);
    in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("dz_sat", 16'(dz_count), 16'd255);
`endif
    out_ready = 1'b0;
    chk("final_vld", 16'(out_valid), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
